// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU's fetch port (A), its data port (B) and the
// single downstream memory port. The arbiter takes the slave view; the
// datapath/memory environment takes the master view.
interface mem_port_arbiter_if;
  // port A: instruction fetch, read-only
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  // port B: data, read/write
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  // shared memory side
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport slave (
    input  read_a, address_a, read_b, write_b, wmask_b, address_b, wdata_b,
           mem_resp, mem_rdata,
    output resp_a, rdata_a, resp_b, rdata_b,
           mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );

  modport master (
    output read_a, address_a, read_b, write_b, wmask_b, address_b, wdata_b,
           mem_resp, mem_rdata,
    input  resp_a, rdata_a, resp_b, rdata_b,
           mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter. Port B (data) beats port A (fetch)
// unless MEM_ARB_ROUND_ROBIN_EN is defined, in which case a 1-bit pointer
// alternates contested grants. The winning request is registered onto the
// mem_* outputs; responses are routed back only to the granted port. A
// watchdog (TIMEOUT_CYCLES, 0 = off) aborts transactions that never respond.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic             req_a, req_b, prefer_b;
  logic             grant_a, grant_b, done, abort;
  logic [TMO_W-1:0] tmo_cnt, tmo_inc;
  logic             tmo_hit;

  logic             mem_read_q, mem_write_q;
  logic [1:0]       mem_wmask_q;
  logic [15:0]      mem_address_q, mem_wdata_q;

  assign req_a = bus.read_a;
  assign req_b = bus.read_b | bus.write_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // pointer flips toward the port that lost (or wasn't) granted
  always_ff @(posedge clk) begin
    if (reset)                  prefer_b <= 1'b1;
    else if (grant_a | grant_b) prefer_b <= grant_a;
  end
`else
  assign prefer_b = 1'b1;
`endif

  // saturating increment; the abort normally fires long before saturation
  assign tmo_inc = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIM);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // arbitration and transaction completion / abort
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req_b && (!req_a || prefer_b)) begin
          grant_b   = 1'b1;
          state_nxt = SERVE_B;
        end else if (req_a) begin
          grant_a   = 1'b1;
          state_nxt = SERVE_A;
        end
      end
      SERVE_A, SERVE_B: begin
        if (bus.mem_resp) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // watchdog: zero while idle so every SERVE entry starts from 0
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) tmo_cnt <= '0;
    else if (!bus.mem_resp)     tmo_cnt <= tmo_inc;
  end

  // abort pulse lands in the IDLE cycle that follows the last SERVE cycle
  always_ff @(posedge clk) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= abort;
  end

  // capture the winner; hold while serving; zero whenever heading to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else if (grant_b) begin
      mem_read_q    <= bus.read_b & ~bus.write_b;  // read+write counts as write
      mem_write_q   <= bus.write_b;
      mem_wmask_q   <= bus.wmask_b;
      mem_address_q <= bus.address_b;
      mem_wdata_q   <= bus.wdata_b;
    end else if (grant_a) begin
      mem_read_q    <= 1'b1;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= bus.address_a;
      mem_wdata_q   <= '0;
    end else if (state_nxt == IDLE) begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

  // responses only reach the granted port; a reset cycle kills any in flight
  assign bus.resp_a  = (state == SERVE_A) & bus.mem_resp & ~reset;
  assign bus.resp_b  = (state == SERVE_B) & bus.mem_resp & ~reset;
  assign bus.rdata_a = bus.resp_a ? bus.mem_rdata : 16'h0000;
  assign bus.rdata_b = bus.resp_b ? bus.mem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (watchdog set to 4 cycles).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic timeout_err;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.read_a = 0; bus.address_a = 0;
    bus.read_b = 0; bus.write_b = 0; bus.wmask_b = 0;
    bus.address_b = 0; bus.wdata_b = 0;
    bus.mem_resp = 0; bus.mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; clear_inputs();
    @(negedge clk);
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    bus.read_a = 1; bus.address_a = 16'h1111;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_wmask, bus.mem_address, bus.mem_wdata} !== 36'h0) begin
      failures++; $display("FAIL reset_mem got rd=%b wr=%b addr=%h exp all 0", bus.mem_read, bus.mem_write, bus.mem_address);
    end
    checks++;
    if ({bus.resp_a, bus.resp_b, timeout_err, bus.rdata_a, bus.rdata_b} !== 35'h0) begin
      failures++; $display("FAIL reset_resp got ra=%b rb=%b to=%b exp 0", bus.resp_a, bus.resp_b, timeout_err);
    end
    reset = 0; bus.read_a = 0;
    @(negedge clk);
  endtask

  task automatic test_read_a();
    do_reset();
    bus.read_a = 1; bus.address_a = 16'h0040; #1;
    checks++;
    if (bus.mem_read !== 1'b0) begin failures++; $display("FAIL rda_req_cycle mem_read=%b exp 0", bus.mem_read); end
    @(negedge clk); #1;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_address !== 16'h0040) begin
      failures++; $display("FAIL rda_issue rd=%b wr=%b addr=%h exp 1 0 0040", bus.mem_read, bus.mem_write, bus.mem_address);
    end
    bus.address_a = 16'hFFFF;  // must be ignored while serving
    @(negedge clk); #1;
    checks++;
    if (bus.mem_address !== 16'h0040 || bus.resp_a !== 1'b0) begin
      failures++; $display("FAIL rda_hold addr=%h resp_a=%b exp 0040 0", bus.mem_address, bus.resp_a);
    end
    @(negedge clk); bus.mem_resp = 1; bus.mem_rdata = 16'h1234; #1;
    checks++;
    if (bus.resp_a !== 1'b1 || bus.rdata_a !== 16'h1234 || bus.resp_b !== 1'b0 || bus.rdata_b !== 16'h0) begin
      failures++; $display("FAIL rda_resp ra=%b rdata_a=%h rb=%b exp 1 1234 0", bus.resp_a, bus.rdata_a, bus.resp_b);
    end
    @(negedge clk); bus.mem_resp = 0; bus.read_a = 0; #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.resp_a !== 1'b0 || bus.rdata_a !== 16'h0) begin
      failures++; $display("FAIL rda_done rd=%b ra=%b rdata_a=%h exp 0 0 0", bus.mem_read, bus.resp_a, bus.rdata_a);
    end
  endtask

  task automatic test_write_b();
    do_reset();
    bus.write_b = 1; bus.address_b = 16'h2000; bus.wdata_b = 16'hBEEF; bus.wmask_b = 2'b01;
    @(negedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wmask !== 2'b01 ||
        bus.mem_wdata !== 16'hBEEF || bus.mem_address !== 16'h2000) begin
      failures++; $display("FAIL wrb_issue wr=%b rd=%b mask=%b wdata=%h addr=%h exp 1 0 01 beef 2000",
        bus.mem_write, bus.mem_read, bus.mem_wmask, bus.mem_wdata, bus.mem_address);
    end
    @(negedge clk); bus.mem_resp = 1; bus.mem_rdata = 16'h5555; #1;
    checks++;
    if (bus.resp_b !== 1'b1 || bus.resp_a !== 1'b0 || bus.mem_read !== 1'b0) begin
      failures++; $display("FAIL wrb_resp rb=%b ra=%b rd=%b exp 1 0 0", bus.resp_b, bus.resp_a, bus.mem_read);
    end
    @(negedge clk); bus.mem_resp = 0; bus.write_b = 0; #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.resp_b !== 1'b0) begin
      failures++; $display("FAIL wrb_done wr=%b rd=%b rb=%b exp 0 0 0", bus.mem_write, bus.mem_read, bus.resp_b);
    end
  endtask

  task automatic test_rw_both();
    do_reset();
    bus.read_b = 1; bus.write_b = 1; bus.address_b = 16'h0404; bus.wmask_b = 2'b11;
    @(negedge clk); #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b1) begin
      failures++; $display("FAIL rw_both rd=%b wr=%b exp 0 1", bus.mem_read, bus.mem_write);
    end
    bus.mem_resp = 1;
    @(negedge clk); bus.mem_resp = 0; bus.read_b = 0; bus.write_b = 0;
  endtask

  task automatic test_contend();
    do_reset();
    bus.read_a = 1; bus.address_a = 16'h0100; bus.read_b = 1; bus.address_b = 16'h0200;
    @(negedge clk); bus.mem_resp = 1; bus.mem_rdata = 16'hB0B0; #1;
    checks++;
    if (bus.mem_address !== 16'h0200 || bus.resp_b !== 1'b1 || bus.resp_a !== 1'b0) begin
      failures++; $display("FAIL contend_first addr=%h rb=%b ra=%b exp 0200 1 0", bus.mem_address, bus.resp_b, bus.resp_a);
    end
    @(negedge clk); bus.mem_resp = 0; bus.read_b = 0; #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0) begin
      failures++; $display("FAIL contend_bubble rd=%b ra=%b rb=%b exp 0 0 0", bus.mem_read, bus.resp_a, bus.resp_b);
    end
    @(negedge clk); bus.mem_resp = 1; bus.mem_rdata = 16'hA0A0; #1;
    checks++;
    if (bus.mem_address !== 16'h0100 || bus.resp_a !== 1'b1 || bus.rdata_a !== 16'hA0A0 || bus.resp_b !== 1'b0) begin
      failures++; $display("FAIL contend_second addr=%h ra=%b rdata_a=%h rb=%b exp 0100 1 a0a0 0",
        bus.mem_address, bus.resp_a, bus.rdata_a, bus.resp_b);
    end
    @(negedge clk); bus.mem_resp = 0; bus.read_a = 0;
  endtask

  task automatic test_stream();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'h0B0B;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_addr[1] = 16'h0A0A; exp_addr[2] = 16'h0B0B; exp_addr[3] = 16'h0A0A;
`else
    exp_addr[1] = 16'h0B0B; exp_addr[2] = 16'h0B0B; exp_addr[3] = 16'h0B0B;
`endif
    do_reset();
    bus.read_a = 1; bus.address_a = 16'h0A0A; bus.read_b = 1; bus.address_b = 16'h0B0B;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      @(negedge clk); #1;
      while (bus.mem_read !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if (n >= 10 || bus.mem_address !== exp_addr[g]) begin
        failures++; $display("FAIL stream_grant%0d addr=%h waited=%0d exp %h", g, bus.mem_address, n, exp_addr[g]);
      end
      bus.mem_resp = 1;
      @(negedge clk); bus.mem_resp = 0;
    end
    bus.read_a = 0; bus.read_b = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    bus.read_a = 1; bus.address_a = 16'h0077;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.mem_read !== 1'b1 || timeout_err !== 1'b0) begin
        failures++; $display("FAIL tmo_serve%0d rd=%b to=%b exp 1 0", c, bus.mem_read, timeout_err);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (timeout_err !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 16'h0 || bus.resp_a !== 1'b0) begin
      failures++; $display("FAIL tmo_abort to=%b rd=%b addr=%h ra=%b exp 1 0 0000 0",
        timeout_err, bus.mem_read, bus.mem_address, bus.resp_a);
    end
    @(negedge clk); #1;
    checks++;
    if (timeout_err !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0077) begin
      failures++; $display("FAIL tmo_regrant to=%b rd=%b addr=%h exp 0 1 0077", timeout_err, bus.mem_read, bus.mem_address);
    end
    bus.read_a = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.read_b = 1; bus.address_b = 16'h0300;
    @(negedge clk); #1;
    checks++;
    if (bus.mem_read !== 1'b1) begin failures++; $display("FAIL rstmid_serve rd=%b exp 1", bus.mem_read); end
    reset = 1;
    @(negedge clk); reset = 0; bus.read_b = 0; bus.mem_resp = 1; bus.mem_rdata = 16'hDEAD; #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_address !== 16'h0 || bus.resp_b !== 1'b0 || bus.rdata_b !== 16'h0) begin
      failures++; $display("FAIL rstmid_late rd=%b addr=%h rb=%b rdata_b=%h exp 0 0000 0 0000",
        bus.mem_read, bus.mem_address, bus.resp_b, bus.rdata_b);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0 || bus.mem_read !== 1'b0) begin
      failures++; $display("FAIL idle_stale ra=%b rb=%b rd=%b exp 0 0 0", bus.resp_a, bus.resp_b, bus.mem_read);
    end
    bus.mem_resp = 0;
  endtask

  initial begin
    test_reset();
    test_read_a();
    test_write_b();
    test_rw_both();
    test_contend();
    test_stream();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "bench timeout");
  end
endmodule
